// File: rtl/mem_responder.sv
// mem_responder: four-phase MAR/MDR memory responder with programmable wait states.
// Optional out-of-range fault detection is enabled by defining MEM_FAULT_EN.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] MdataIn,
    output logic        Done,
    output logic        Busy,
    output logic        Fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_next;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
    logic              op_rd;
    logic              bad;
    logic              req;
    logic              accept;
    logic              commit;
    logic [31:0]       mem [DEPTH];
    assign req    = Read | Write;
    assign accept = state == IDLE && req;
    assign commit = state == ACCESS && cnt == 4'd0;
    assign Busy   = state != IDLE;
    assign Done   = state == DONE;
    always_ff @(posedge clk) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_next;
    end
    // A held request parks in DONE, so it can never retrigger a second access.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = req ? ACCESS : IDLE;
            ACCESS:  state_next = commit ? DONE : ACCESS;
            DONE:    state_next = req ? DONE : IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt     <= 4'd0;
            MdataIn <= 32'd0;
        end else if (accept) begin
            idx   <= Address[ADDR_W-1:0];
            data  <= WriteData;
            op_rd <= Read;
            cnt   <= 4'(WAIT_CYCLES);
        end else if (state == ACCESS) begin
            cnt <= commit ? cnt : cnt - 4'd1;
            if (commit && op_rd && !bad)
                MdataIn <= mem[idx];
        end
    end
    // No reset on the array; clr only blocks an in-flight write from landing.
    always_ff @(posedge clk) begin
        if (!clr && commit && !op_rd && !bad)
            mem[idx] <= data;
    end
`ifdef MEM_FAULT_EN
    always_ff @(posedge clk) begin
        if (clr)
            bad <= 1'b0;
        else if (accept)
            bad <= Address >= 32'(DEPTH);
    end
    assign Fault = Done & bad;
`else
    logic unused_hi;
    assign unused_hi = ^Address[31:ADDR_W];
    assign bad       = 1'b0;
    assign Fault     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_mem_responder;
    localparam int W = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        clr, rd, wr, done, busy, fault;
    logic [31:0] addr, wdata, mdata;
    logic        rd0, wr0, done0, busy0, fault0;
    logic [31:0] addr0, wdata0, mdata0;
    int          compared = 0, mismatched = 0;
    logic [31:0] expq[$];
    logic [31:0] last_rd = 32'd0;

    mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(W)) dut (
        .clk(clk), .clr(clr), .Address(addr), .WriteData(wdata), .Read(rd), .Write(wr),
        .MdataIn(mdata), .Done(done), .Busy(busy), .Fault(fault));

    mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .Address(addr0), .WriteData(wdata0), .Read(rd0), .Write(wr0),
        .MdataIn(mdata0), .Done(done0), .Busy(busy0), .Fault(fault0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete handshake; the expected MdataIn is queued at drive time and popped at Done.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input logic exp_f, input int hold, input string tag);
        int e;
        logic [31:0] exp_v;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        exp_v = (r && !exp_f) ? rdata : last_rd;
        expq.push_back(exp_v);
        e = 0;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
            if (e == 1) chk({tag, " busy"}, 32'(busy), 32'd1);
        end
        chk({tag, " latency"}, e, W + 2);
        chk({tag, " data"}, mdata, expq.pop_front());
        chk({tag, " fault"}, 32'(fault), 32'(exp_f));
        last_rd = exp_v;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " held done"}, {busy, done}, 2'b11);
        end
        if (hold > 0) chk({tag, " held data"}, mdata, exp_v);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk({tag, " release"}, {busy, done, fault}, 3'b000);
    endtask

    initial begin
        clr = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset outs", {mdata, 29'd0, busy, done, fault}, 64'd0);
        chk("reset outs0", {mdata0, 29'd0, busy0, done0, fault0}, 64'd0);
        clr = 1'b0;

        access(1'b0, 1'b1, 32'h010, 32'h12345678, 32'h0, 1'b0, 0, "wr010");
        access(1'b1, 1'b0, 32'h010, 32'h0, 32'h12345678, 1'b0, 0, "rd010");
        access(1'b1, 1'b0, 32'h010, 32'h0, 32'h12345678, 1'b0, 10, "hold");
        access(1'b1, 1'b0, 32'h010, 32'h0, 32'h12345678, 1'b0, 0, "reraise");

        access(1'b0, 1'b1, 32'h020, 32'h00000000, 32'h0, 1'b0, 0, "pre020");
        access(1'b1, 1'b1, 32'h020, 32'hDEADBEEF, 32'h00000000, 1'b0, 0, "collide");
        access(1'b1, 1'b0, 32'h020, 32'h0, 32'h00000000, 1'b0, 0, "rd020");

        access(1'b0, 1'b1, 32'h030, 32'h0000AAAA, 32'h0, 1'b0, 0, "wr030");
        access(1'b1, 1'b0, 32'h030, 32'h0, 32'h0000AAAA, 1'b0, 0, "rd030a");
        @(negedge clk);
        wr = 1'b1; addr = 32'h030; wdata = 32'h0000BBBB;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd1);
        clr = 1'b1; wr = 1'b0;
        @(negedge clk);
        chk("abort outs", {mdata, 30'd0, busy, done}, 64'd0);
        clr = 1'b0;
        last_rd = 32'd0;
        access(1'b1, 1'b0, 32'h030, 32'h0, 32'h0000AAAA, 1'b0, 0, "rd030b");

        access(1'b0, 1'b1, 32'h005, 32'h00000077, 32'h0, 1'b0, 0, "pre005");
`ifdef MEM_FAULT_EN
        access(1'b0, 1'b1, 32'h205, 32'h00000055, 32'h0, 1'b1, 0, "wr205");
        access(1'b1, 1'b0, 32'h005, 32'h0, 32'h00000077, 1'b0, 0, "rd005");
`else
        access(1'b0, 1'b1, 32'h205, 32'h00000055, 32'h0, 1'b0, 0, "wr205");
        access(1'b1, 1'b0, 32'h005, 32'h0, 32'h00000055, 1'b0, 0, "rd005");
`endif

        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h010; wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        chk("z wr early", {busy0, done0}, 2'b10);
        @(negedge clk);
        chk("z wr done", {31'd0, done0, mdata0}, {31'd1, 32'd0, 1'b0} >> 1);
        wr0 = 1'b0;
        @(negedge clk);
        chk("z wr release", 32'(done0), 32'd0);
        rd0 = 1'b1;
        @(negedge clk);
        chk("z rd early", {done0, mdata0}, 33'd0);
        @(negedge clk);
        chk("z rd done", 32'(done0), 32'd1);
        chk("z rd data", mdata0, 32'hCAFEF00D);
        rd0 = 1'b0;
        @(negedge clk);
        chk("z rd release", 32'(done0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR interface.
- Accepts read/write requests from the CPU control unit on a four-phase handshake.
- Serves them from an internal word-addressed RAM after a programmable number of wait states.
- Drives the MdataIn word that the MDR captures when Read is asserted; stores MDR contents on writes.

Parameters:
- ADDR_W, 9: index width; memory holds 2**ADDR_W 32-bit words.
- DEPTH, 512: number of implemented words; must equal 2**ADDR_W.
- WAIT_CYCLES, 2: extra access cycles before completion, 0..15.

Ports:
- clk  input  1: clock; all state changes on rising edge.
- clr  input  1: synchronous active-high reset.
- Address  input  32: word address from MAR.
- WriteData  input  32: word to store, driven from MDR output.
- Read  input  1: read request level.
- Write  input  1: write request level.
- MdataIn  output  32: last read word, registered, toward MDR.
- Done  output  1: access complete, held until request released.
- Busy  output  1: high in ACCESS and DONE states.
- Fault  output  1: out-of-range access flag; present only with MEM_FAULT_EN, otherwise tied 0.

Behaviour:
- Reset (clr=1 at rising edge):
  - state<=IDLE; MdataIn, Done, Busy and Fault <= 0; wait counter <= 0.
  - RAM contents are NOT cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If Read|Write is sampled high, latch Address[ADDR_W-1:0], WriteData, and op (read if Read=1, else write).
  - Load counter=WAIT_CYCLES; go to ACCESS. Busy=1 from next cycle.
- Simultaneous Read=1 and Write=1: treated as a read; no write is committed.
- Request inputs are ignored outside IDLE; latched values are used for the whole access.
- ACCESS:
  - Counter decrements each cycle.
  - On the cycle the counter is 0, perform the access:
    - write: mem[idx] <= latched data.
    - read: MdataIn <= mem[idx].
  - Go to DONE in the same edge.
- Latency: request sampled at edge N -> Done=1 after edge N+WAIT_CYCLES+1. MdataIn is valid at the same edge.
- DONE:
  - Done=1 and Busy=1, held while Read|Write remains high.
  - When Read=0 and Write=0 are sampled: Done<=0, Busy<=0, go to IDLE.
  - A new request is accepted on the following IDLE cycle at the earliest, so a held request never retriggers.
- MdataIn changes only on completion of a read or on reset. Writes leave it unchanged.
- MdataIn is stable from Done rising until the next read completes, so the MDR's falling-edge capture is safe.
- Address upper bits [31:ADDR_W] are ignored; addresses alias modulo DEPTH.
- Reset mid-operation (ACCESS or DONE): the access is aborted, a pending write is not committed, MdataIn <= 0.

Optional Feature:
- Macro: MEM_FAULT_EN
- Defined:
  - In IDLE, Address >= DEPTH is latched as a fault.
  - The access follows the normal timing but commits nothing: no write, MdataIn unchanged.
  - Fault=1 asserted together with Done and cleared with it.
- Undefined:
  - Fault port tied 0.
  - Addresses alias as described above.

Test Plan:
- Write then read (WAIT_CYCLES=2): Write, Address=0x010, WriteData=0x12345678 -> Done after 3 edges; release; then Read 0x010 -> MdataIn=0x12345678 and Done after 3 edges.
- Held request: keep Read=1 for 10 cycles after Done -> Done stays 1 with exactly one access; drop Read -> Done=0 next edge; re-raise -> new access begins.
- Read/Write collision: preload 0x020=0x00000000; assert Read=Write=1, WriteData=0xDEADBEEF -> MdataIn=0x00000000; subsequent read of 0x020 returns 0x00000000.
- Reset mid-write: write 0x0000AAAA to 0x030; then start write 0x0000BBBB to 0x030; assert clr one cycle into ACCESS -> Busy=Done=MdataIn=0; later read of 0x030 returns 0x0000AAAA.
- Aliasing/fault:
  - Default build: write 0x55 to Address 0x205 -> read 0x005 returns 0x55.
  - MEM_FAULT_EN build: the same write gives Fault=1 with Done, and read 0x005 returns its prior value.
- Zero-wait instance (WAIT_CYCLES=0): Read 0x010 sampled at edge N -> Done=1 and MdataIn valid after edge N+1.
